frog_collision_detect: RTL and testbench

- Sits directly upstream of the game-over display stage and produces the `hit` level that stage latches.
- Once per frame it scans the 16x16 red (car/hazard) pixel array one row per cycle and tests the frog's pixel against the hazard at the frog's position.
- It tracks remaining lives with a post-collision grace window.
- When the last life is lost it asserts `hit` and holds it until reset.

---
 rtl/frog_collision_detect_pkg.sv | 20 ++
 rtl/frog_collision_detect_if.sv | 25 ++
 rtl/frog_collision_detect_row_scanner.sv | 28 ++
 rtl/frog_collision_detect.sv | 113 +++++++++++
 tb/tb_frog_collision_detect.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/frog_collision_detect_pkg.sv
// Shared types and constants for the frog collision path.
// Used by the collision detector, its row scanner and the bus interface.
package frogger_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int LIVES_DEF = 3;
  localparam int GRACE_DEF = 4;

  typedef logic [COLS-1:0] row_t;
  typedef logic [3:0]      coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL,
    DEAD
  } state_t;

endpackage

// File: rtl/frog_collision_detect_if.sv
// Frame/scan bus between the game logic and the collision detector.
// master drives frame and pixel data, slave returns scan address and status.
interface frog_collision_detect_if;
  import frogger_pkg::*;

  logic       frame_start;
  coord_t     frog_row;
  coord_t     frog_col;
  row_t       red_row;
  coord_t     row_idx;
  logic       collide;
  logic [1:0] lives;
  logic       hit;

  modport master (
    output frame_start, frog_row, frog_col, red_row,
    input  row_idx, collide, lives, hit
  );

  modport slave (
    input  frame_start, frog_row, frog_col, red_row,
    output row_idx, collide, lives, hit
  );

endinterface

// File: rtl/frog_collision_detect_row_scanner.sv
// Row address counter: restarts on start, steps on en, wraps after N-1.
// Kept separate so the display path can share the same scan sequencing.
module row_scanner
  import frogger_pkg::*;
#(
  parameter int N = ROWS
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   en,
  output coord_t idx,
  output logic   last
);

  assign last = (idx == coord_t'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/frog_collision_detect.sv
// Per-frame frog/hazard overlap test with lives, grace window and
// a sticky game-over flag.
module frog_collision_detect
  import frogger_pkg::*;
#(
  parameter int LIVES        = LIVES_DEF,
  parameter int GRACE_FRAMES = GRACE_DEF
) (
  input logic                    clk,
  input logic                    reset,
  frog_collision_detect_if.slave bus
);

  state_t     state, state_d;
  coord_t     frow_q, frow_d;
  coord_t     fcol_q, fcol_d;
  logic       ovl_q, ovl_d;
  logic [2:0] grace_q, grace_d;
  logic [1:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic       coll_q, coll_d;
  logic       scan_start;
  logic       scan_en;
  logic       scan_last;
  coord_t     row_idx;

  row_scanner #(.N(ROWS)) u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .en    (scan_en),
    .idx   (row_idx),
    .last  (scan_last)
  );

  always_comb begin
    state_d    = state;
    frow_d     = frow_q;
    fcol_d     = fcol_q;
    ovl_d      = ovl_q;
    grace_d    = grace_q;
    lives_d    = lives_q;
    hit_d      = hit_q;
    coll_d     = 1'b0;
    scan_start = 1'b0;
    scan_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.frame_start) begin
          frow_d     = bus.frog_row;
          fcol_d     = bus.frog_col;
          ovl_d      = 1'b0;
          scan_start = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (row_idx == frow_q) begin
          ovl_d = bus.red_row[fcol_q];
        end
        if (scan_last) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (ovl_q && grace_q == 3'd0 && lives_q != 2'd0) begin
          lives_d = lives_q - 2'd1;
          coll_d  = 1'b1;
          grace_d = 3'(GRACE_FRAMES);
          if (lives_q == 2'd1) begin
            hit_d   = 1'b1;
            state_d = DEAD;
          end
        end else if (grace_q != 3'd0) begin
          grace_d = grace_q - 3'd1;
        end
      end
      DEAD: begin
        hit_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      frow_q  <= '0;
      fcol_q  <= '0;
      ovl_q   <= 1'b0;
      grace_q <= '0;
      lives_q <= 2'(LIVES);
      hit_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state   <= state_d;
      frow_q  <= frow_d;
      fcol_q  <= fcol_d;
      ovl_q   <= ovl_d;
      grace_q <= grace_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.row_idx = row_idx;
  assign bus.collide = coll_q;
  assign bus.lives   = lives_q;
  assign bus.hit     = hit_q;

endmodule

// File: tb/tb_frog_collision_detect.sv
// Directed bench for frog_collision_detect: frame table plus
// hand-written mid-scan, EVAL-drop, death and reset sequences.
module tb_frog_collision_detect;
  import frogger_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  frog_collision_detect_if bus ();

  frog_collision_detect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  coord_t haz_row;
  row_t   haz_mask;

  always_comb begin
    bus.red_row = (bus.row_idx == haz_row) ? haz_mask : '0;
  end

  typedef struct {
    coord_t     fr;
    coord_t     fc;
    coord_t     hr;
    row_t       hm;
    logic       c;
    logic [1:0] l;
    logic       h;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Leaves the bench in cycle 18 (or just after reset when rst_at hits).
  task automatic frame(input coord_t fr, input coord_t fc,
                       input int pulse_at, input int move_at,
                       input int rst_at);
    bit     bad_idx;
    bit     early;
    coord_t e;
    bad_idx = 0;
    early   = 0;
    bus.frog_row    = fr;
    bus.frog_col    = fc;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_lives", bus.lives, 3);
        chk("rst_mid_hit", bus.hit, 0);
        chk("rst_mid_collide", bus.collide, 0);
        chk("rst_mid_row_idx", bus.row_idx, 0);
        return;
      end
      e = (c <= 16) ? coord_t'(c - 1) : '0;
      if (bus.row_idx !== e) bad_idx = 1;
      if (bus.collide !== 1'b0) early = 1;
      if (c == move_at) begin
        bus.frog_row = 4'd5;
        bus.frog_col = 4'd7;
      end
      bus.frame_start = (c == pulse_at);
      step();
    end
    bus.frame_start = 1'b0;
    chk("row_idx_seq", bad_idx, 0);
    chk("collide_early", early, 0);
  endtask

  task automatic frame_end(input logic c, input logic [1:0] l,
                           input logic h);
    chk("collide_c18", bus.collide, c);
    chk("lives_c18", bus.lives, l);
    chk("hit_c18", bus.hit, h);
    step();
    chk("collide_pulse", bus.collide, 0);
  endtask

  task automatic idle_quiet(input int n);
    bit moved;
    moved = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.row_idx !== 4'd0 || bus.collide !== 1'b0) moved = 1;
      step();
    end
    chk("idle_quiet", moved, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'd5,  4'd7,  4'd5,  16'h0000, 1'b0, 2'd3, 1'b0};
    tbl[1]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b1, 2'd2, 1'b0};
    tbl[2]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b0, 2'd2, 1'b0};
    tbl[4]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b0, 2'd2, 1'b0};
    tbl[5]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{4'd5,  4'd7,  4'd5,  16'h0080, 1'b1, 2'd1, 1'b0};
    tbl[7]  = '{4'd0,  4'd0,  4'd0,  16'h0001, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{4'd15, 4'd15, 4'd15, 16'h8000, 1'b0, 2'd1, 1'b0};
    tbl[9]  = '{4'd15, 4'd15, 4'd15, 16'h8000, 1'b0, 2'd1, 1'b0};
    tbl[10] = '{4'd15, 4'd15, 4'd15, 16'h8000, 1'b0, 2'd1, 1'b0};
    tbl[11] = '{4'd3,  4'd2,  4'd3,  16'hFFFB, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{4'd15, 4'd15, 4'd15, 16'h8000, 1'b1, 2'd0, 1'b1};

    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.frog_row    = '0;
    bus.frog_col    = '0;
    haz_row         = '0;
    haz_mask        = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_row_idx", bus.row_idx, 0);
    chk("rst_lives", bus.lives, 3);
    chk("rst_hit", bus.hit, 0);
    chk("rst_collide", bus.collide, 0);

    for (int i = 0; i < 13; i++) begin
      haz_row  = tbl[i].hr;
      haz_mask = tbl[i].hm;
      frame(tbl[i].fr, tbl[i].fc, 0, 0, 0);
      frame_end(tbl[i].c, tbl[i].l, tbl[i].h);
    end

    begin
      bit bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        bus.frame_start = (i % 10 == 0);
        if (bus.hit !== 1'b1 || bus.row_idx !== 4'd0 ||
            bus.lives !== 2'd0 || bus.collide !== 1'b0) bad = 1;
        step();
      end
      bus.frame_start = 1'b0;
      chk("dead_hold", bad, 0);
    end

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_lives", bus.lives, 3);
    chk("rst2_hit", bus.hit, 0);

    haz_row  = 4'd5;
    haz_mask = 16'h0080;
    frame(4'd2, 4'd3, 8, 2, 0);
    frame_end(1'b0, 2'd3, 1'b0);
    idle_quiet(20);

    haz_mask = 16'h0000;
    frame(4'd2, 4'd3, 17, 0, 0);
    frame_end(1'b0, 2'd3, 1'b0);
    idle_quiet(20);

    haz_mask = 16'h0080;
    for (int i = 0; i < 6; i++) begin
      frame(4'd5, 4'd7, 0, 0, 0);
      step();
    end
    chk("setup_lives", bus.lives, 1);
    frame(4'd5, 4'd7, 0, 0, 10);
    idle_quiet(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
